// File: rtl/bht_maint_ctrl_pkg.sv
// Shared types for the BHT maintenance controller.
//   BHT_IDX_W      : default BHT index width (2**BHT_IDX_W entries)
//   bht_ctr_t      : 2-bit saturating counter encoding, BHT_INIT_STATE = WNT
//   bht_upd_t      : buffered branch update {idx, taken}
//   maint_state_t  : controller FSM state
package bp_pkg;

  localparam int BHT_IDX_W = 10;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_t;

  localparam bht_ctr_t BHT_INIT_STATE = WNT;

  typedef struct packed {
    logic [BHT_IDX_W-1:0] idx;
    logic                 taken;
  } bht_upd_t;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } maint_state_t;

endpackage

// File: rtl/bht_maint_ctrl_if.sv
// Branch-update / BHT write-port bundle for bht_maint_ctrl.
//   master : EX stage + BHT side (drives i_*, observes o_*)
//   slave  : the controller (observes i_*, drives o_*)
//   i_upd_valid/i_upd_pc/i_upd_taken : resolved branch from EX
//   i_flush_req                      : re-initialise the whole table
//   i_bht_ready                      : BHT write port free this cycle
//   o_bht_wen/o_bht_idx/o_bht_init/o_bht_taken : BHT write port
//   o_pred_en, o_busy                : prediction gate, sweep in progress
interface bht_maint_ctrl_if #(
  parameter int IDX_W = bp_pkg::BHT_IDX_W
);
  logic             i_upd_valid;
  logic [31:0]      i_upd_pc;
  logic             i_upd_taken;
  logic             i_flush_req;
  logic             i_bht_ready;
  logic             o_bht_wen;
  logic [IDX_W-1:0] o_bht_idx;
  logic             o_bht_init;
  logic             o_bht_taken;
  logic             o_pred_en;
  logic             o_busy;

  modport master (
    output i_upd_valid, i_upd_pc, i_upd_taken, i_flush_req, i_bht_ready,
    input  o_bht_wen, o_bht_idx, o_bht_init, o_bht_taken, o_pred_en, o_busy
  );

  modport slave (
    input  i_upd_valid, i_upd_pc, i_upd_taken, i_flush_req, i_bht_ready,
    output o_bht_wen, o_bht_idx, o_bht_init, o_bht_taken, o_pred_en, o_busy
  );
endinterface

// File: rtl/bht_maint_ctrl_fifo.sv
// bht_upd_fifo: synchronous FIFO of bht_upd_t, no internal bypass.
//   i_push/i_data : enqueue (accepted when not full, or when popping)
//   i_pop         : dequeue head (ignored when empty)
//   i_clear       : synchronous flush, wins over push/pop
//   o_head        : current head entry
//   o_full/o_empty: occupancy flags
module bht_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     i_clk,
  input  logic     i_reset_n,
  input  logic     i_push,
  input  logic     i_pop,
  input  logic     i_clear,
  input  bht_upd_t i_data,
  output bht_upd_t o_head,
  output logic     o_full,
  output logic     o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  bht_upd_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop && !o_empty;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + {{PTR_W{1'b0}}, w_push_ok} - {{PTR_W{1'b0}}, w_pop_ok};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/bht_maint_ctrl.sv
// bht_maint_ctrl: sequences the BHT write port.
//   Sweeps all entries to weakly-not-taken after reset and on flush, buffers
//   resolved-branch updates while the port is busy, gates ID prediction.
//   i_clk, i_reset_n : clock, async active-low reset
//   bus (slave)      : update inputs, flush, BHT write port, pred_en, busy
//   o_upd_cnt/o_drop_cnt : only with BHT_PERF_CNT_EN defined
// Optional feature macro: BHT_PERF_CNT_EN (performance counters).
// IDX_W must equal bp_pkg::BHT_IDX_W since bht_upd_t is sized by it.
//
// state | meaning
// INIT  | post-reset sweep, writes WNT to every entry
// RUN   | normal operation, updates written via bypass or FIFO
// FLUSH | flush-requested sweep, identical to INIT
module bht_maint_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_W      = BHT_IDX_W,
  parameter int FIFO_DEPTH = 4
) (
  input logic              i_clk,
  input logic              i_reset_n,
  bht_maint_ctrl_if.slave  bus
`ifdef BHT_PERF_CNT_EN
  ,
  output logic [31:0]      o_upd_cnt,
  output logic [31:0]      o_drop_cnt
`endif
);
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  maint_state_t     r_state, w_state_nxt;
  logic [IDX_W-1:0] r_sweep_idx, w_sweep_idx_nxt;
  logic [IDX_W-1:0] r_idx_hold;
  logic             r_taken_hold;

  logic             w_sweep, w_run;
  bht_upd_t         w_upd, w_head;
  logic             w_fifo_full, w_fifo_empty;
  logic             w_bypass, w_head_wr, w_push, w_clear, w_wen;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_wr_taken;
  logic             w_unused_pc;

  assign w_unused_pc = ^{bus.i_upd_pc[31:IDX_W+2], bus.i_upd_pc[1:0]};

  assign w_sweep   = (r_state != RUN);
  assign w_run     = !w_sweep;
  assign w_upd     = '{idx: bus.i_upd_pc[IDX_W+1:2], taken: bus.i_upd_taken};
  // an update coinciding with a flush is stale and must not reach the table
  assign w_bypass  = w_run && bus.i_upd_valid && w_fifo_empty && bus.i_bht_ready && !bus.i_flush_req;
  assign w_head_wr = w_run && !w_fifo_empty && bus.i_bht_ready;
  assign w_push    = w_run && bus.i_upd_valid && !w_bypass && !bus.i_flush_req;
  assign w_clear   = w_run && bus.i_flush_req;
  // reset gates the strobe directly so it drops without waiting for a clock
  assign w_wen     = i_reset_n && (w_sweep ? bus.i_bht_ready : (w_head_wr || w_bypass));

  always_comb begin
    w_wr_idx   = r_sweep_idx;
    w_wr_taken = 1'b0;
    if (w_run) begin
      w_wr_idx   = w_fifo_empty ? w_upd.idx   : w_head.idx;
      w_wr_taken = w_fifo_empty ? w_upd.taken : w_head.taken;
    end
  end

  assign bus.o_bht_wen   = w_wen;
  assign bus.o_bht_idx   = w_wen ? w_wr_idx : r_idx_hold;
  assign bus.o_bht_taken = w_wen ? w_wr_taken : r_taken_hold;
  assign bus.o_bht_init  = w_sweep;
  assign bus.o_pred_en   = w_run;
  assign bus.o_busy      = w_sweep;

  bht_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (w_push),
    .i_pop     (w_head_wr),
    .i_clear   (w_clear),
    .i_data    (w_upd),
    .o_head    (w_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_sweep_idx_nxt = r_sweep_idx;
    case (r_state)
      RUN: begin
        if (bus.i_flush_req) begin
          w_state_nxt     = FLUSH;
          w_sweep_idx_nxt = '0;
        end
      end
      default: begin
        if (bus.i_flush_req) begin
          w_state_nxt     = FLUSH;
          w_sweep_idx_nxt = '0;
        end else if (bus.i_bht_ready) begin
          w_sweep_idx_nxt = r_sweep_idx + IDX_W'(1);
          if (r_sweep_idx == LAST_IDX) w_state_nxt = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= INIT;
      r_sweep_idx  <= '0;
      r_idx_hold   <= '0;
      r_taken_hold <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_idx_nxt;
      if (w_wen) begin
        r_idx_hold   <= w_wr_idx;
        r_taken_hold <= w_wr_taken;
      end
    end
  end

`ifdef BHT_PERF_CNT_EN
  logic w_drop;
  assign w_drop = bus.i_upd_valid &&
                  (w_sweep || (w_push && w_fifo_full && !w_head_wr));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_upd_cnt  <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (w_wen && w_run) o_upd_cnt  <= o_upd_cnt + 32'd1;
      if (w_drop)         o_drop_cnt <= o_drop_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_bht_maint_ctrl.sv
module tb_bht_maint_ctrl;
  import bp_pkg::*;

  typedef struct packed {
    logic [9:0] idx;
    logic       init;
    logic       taken;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t exp_q[$];

  bht_maint_ctrl_if #(.IDX_W(10)) bus();

`ifdef BHT_PERF_CNT_EN
  logic [31:0] upd_cnt;
  logic [31:0] drop_cnt;
`endif

  bht_maint_ctrl #(.IDX_W(10), .FIFO_DEPTH(4)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
`ifdef BHT_PERF_CNT_EN
    ,
    .o_upd_cnt (upd_cnt),
    .o_drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back('{idx: 10'(i), init: 1'b1, taken: 1'b0});
  endtask

  task automatic push_upd(input int idx, input logic tk);
    exp_q.push_back('{idx: 10'(idx), init: 1'b0, taken: tk});
  endtask

  // scoreboard monitor: every BHT write must match the next expected entry
  always @(negedge clk) begin
    if (bus.o_bht_wen === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got idx=%0d init=%0b expected no write at %0t",
                 bus.o_bht_idx, bus.o_bht_init, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.o_bht_idx !== e.idx || bus.o_bht_init !== e.init ||
            (!e.init && bus.o_bht_taken !== e.taken)) begin
          fails++;
          $display("FAIL bht_write: got idx=%0d init=%0b taken=%0b expected idx=%0d init=%0b taken=%0b at %0t",
                   bus.o_bht_idx, bus.o_bht_init, bus.o_bht_taken, e.idx, e.init, e.taken, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.i_upd_valid = 1'b0;
    bus.i_upd_pc    = 32'h0;
    bus.i_upd_taken = 1'b0;
    bus.i_flush_req = 1'b0;
    bus.i_bht_ready = 1'b1;
    #2;
    check("rst_wen",   32'(bus.o_bht_wen),   32'd0);
    check("rst_idx",   32'(bus.o_bht_idx),   32'd0);
    check("rst_init",  32'(bus.o_bht_init),  32'd1);
    check("rst_taken", 32'(bus.o_bht_taken), 32'd0);
    check("rst_pred",  32'(bus.o_pred_en),   32'd0);
    check("rst_busy",  32'(bus.o_busy),      32'd1);

    // 1: initial sweep, 1024 consecutive writes
    @(posedge clk); #1;
    push_sweep(0, 1023);
    rst_n = 1'b1;
    cycles(1023);
    check("t1_pred_before", 32'(bus.o_pred_en), 32'd0);
    cycles(1);
    check("t1_pred_after", 32'(bus.o_pred_en), 32'd1);
    check("t1_busy_after", 32'(bus.o_busy),    32'd0);
    check("t1_drain",      32'(exp_q.size()),  32'd0);

    // 2: zero-latency bypass
    bus.i_upd_valid = 1'b1; bus.i_upd_pc = 32'h40; bus.i_upd_taken = 1'b1;
    push_upd(16, 1'b1);
    cycles(1);
    bus.i_upd_valid = 1'b0;
    check("t2_drain", 32'(exp_q.size()), 32'd0);

    // 3: port stalled, 4 buffered, 5th dropped, drained in order
    bus.i_bht_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.i_upd_valid = 1'b1;
      bus.i_upd_pc    = 32'((i + 1) * 4);
      bus.i_upd_taken = (i % 2 == 0);
      if (i < 4) push_upd(i + 1, (i % 2 == 0));
      cycles(1);
    end
    bus.i_upd_valid = 1'b0;
    check("t3_no_write_stalled", 32'(exp_q.size()), 32'd4);
    bus.i_bht_ready = 1'b1;
    cycles(6);
    check("t3_drain",     32'(exp_q.size()),  32'd0);
    check("t3_idle_wen",  32'(bus.o_bht_wen), 32'd0);
    check("t3_hold_idx",  32'(bus.o_bht_idx), 32'd4);

    // 4: flush with 2 queued entries
    bus.i_bht_ready = 1'b0;
    bus.i_upd_valid = 1'b1; bus.i_upd_pc = 32'h100; bus.i_upd_taken = 1'b1;
    cycles(1);
    bus.i_upd_pc = 32'h104; bus.i_upd_taken = 1'b0;
    cycles(1);
    bus.i_upd_valid = 1'b0;
    bus.i_flush_req = 1'b1;
    cycles(1);
    bus.i_flush_req = 1'b0;
    check("t4_pred_off", 32'(bus.o_pred_en),  32'd0);
    check("t4_busy",     32'(bus.o_busy),     32'd1);
    check("t4_init",     32'(bus.o_bht_init), 32'd1);
    check("t4_wen_off",  32'(bus.o_bht_wen),  32'd0);

    // 5: flush again at sweep idx 500; update during sweep is discarded
    push_sweep(0, 500);
    push_sweep(0, 1023);
    bus.i_bht_ready = 1'b1;
    cycles(100);
    bus.i_upd_valid = 1'b1; bus.i_upd_pc = 32'h80; bus.i_upd_taken = 1'b1;
    cycles(1);
    bus.i_upd_valid = 1'b0;
    cycles(399);
    check("t5_idx_at_pulse", 32'(bus.o_bht_idx), 32'd500);
    bus.i_flush_req = 1'b1;
    cycles(1);
    bus.i_flush_req = 1'b0;
    cycles(1023);
    check("t5_pred_before", 32'(bus.o_pred_en), 32'd0);
    cycles(1);
    check("t5_pred_after", 32'(bus.o_pred_en), 32'd1);
    check("t5_drain",      32'(exp_q.size()),  32'd0);

    // 6a: reset mid-RUN
    bus.i_upd_valid = 1'b1; bus.i_upd_pc = 32'h1FC; bus.i_upd_taken = 1'b1;
    push_upd(127, 1'b1);
    cycles(1);
    bus.i_bht_ready = 1'b0;
    bus.i_upd_pc = 32'h200;
    cycles(1);
    bus.i_upd_valid = 1'b0;
    check("t6_hold_taken", 32'(bus.o_bht_taken), 32'd1);
`ifdef BHT_PERF_CNT_EN
    check("cnt_upd",  upd_cnt,  32'd6);
    check("cnt_drop", drop_cnt, 32'd2);
`endif
    #2;
    rst_n = 1'b0;
    bus.i_bht_ready = 1'b1;
    #1;
    check("t6r_wen",   32'(bus.o_bht_wen),   32'd0);
    check("t6r_idx",   32'(bus.o_bht_idx),   32'd0);
    check("t6r_init",  32'(bus.o_bht_init),  32'd1);
    check("t6r_taken", 32'(bus.o_bht_taken), 32'd0);
    check("t6r_pred",  32'(bus.o_pred_en),   32'd0);
    check("t6r_busy",  32'(bus.o_busy),      32'd1);
`ifdef BHT_PERF_CNT_EN
    check("t6r_cnt_upd",  upd_cnt,  32'd0);
    check("t6r_cnt_drop", drop_cnt, 32'd0);
`endif

    // 6b: reset mid-sweep
    cycles(1);
    push_sweep(0, 9);
    rst_n = 1'b1;
    cycles(10);
    check("t6s_idx_live", 32'(bus.o_bht_idx), 32'd10);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6s_wen",  32'(bus.o_bht_wen),  32'd0);
    check("t6s_idx",  32'(bus.o_bht_idx),  32'd0);
    check("t6s_init", 32'(bus.o_bht_init), 32'd1);
    check("t6s_pred", 32'(bus.o_pred_en),  32'd0);
    check("t6s_busy", 32'(bus.o_busy),     32'd1);
    cycles(2);
    check("t6s_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
